// File: rtl/ddr3_seq_pkg.sv
// ddr3_seq_pkg: shared definitions for the DDR3 DFI sequencer.
//   - state_t   : sequencer FSM state encodings
//   - CMD_*     : 3-bit {ras_n, cas_n, we_n} command encodings
//   - CS_*      : chip-select levels for NOP (selected) / DESELECT
//   - PEND_MAX  : refresh-postpone depth (8 with DDR3_REFRESH_POSTPONE_EN, else 1)
// Optional feature macro: DDR3_REFRESH_POSTPONE_EN
package ddr3_seq_pkg;

  typedef enum logic [3:0] {
    ST_RESET,
    ST_CKEWAIT,
    ST_XPR,
    ST_MR2,
    ST_MR3,
    ST_MR1,
    ST_MR0,
    ST_ZQCL,
    ST_IDLE,
    ST_QUIET,
    ST_PREA,
    ST_REF
  } state_t;

  localparam logic [2:0] CMD_MRS = 3'b000;
  localparam logic [2:0] CMD_REF = 3'b001;
  localparam logic [2:0] CMD_PRE = 3'b010;
  localparam logic [2:0] CMD_ZQC = 3'b110;
  localparam logic [2:0] CMD_NOP = 3'b111;

  localparam logic CS_SELECT   = 1'b0;
  localparam logic CS_DESELECT = 1'b1;

`ifdef DDR3_REFRESH_POSTPONE_EN
  localparam int PEND_MAX = 8;
`else
  localparam int PEND_MAX = 1;
`endif
  localparam int PEND_W = 4;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/ddr3_wait_timer.sv
// ddr3_wait_timer: loadable down-counter used for every sequencer wait.
//   clock, reset_n : clock / async active-low reset (count resets to RST_VAL)
//   load, load_val : load the counter with load_val (priority over counting)
//   expire         : high for exactly one cycle, the cycle before the edge that
//                    lies load_val edges after the load edge
module ddr3_wait_timer #(
  parameter int W       = 16,
  parameter int RST_VAL = 0
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expire
);

  logic [W-1:0] count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= W'(RST_VAL);
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  // Firing at 1 (not 0) lets the FSM register its action on the edge that
  // completes the wait, and the counter parks at 0 so expire never repeats.
  assign expire = (count == W'(1));

endmodule

// File: rtl/ddr3_dfi_sequencer.sv
// ddr3_dfi_sequencer: owns the DFI command bus to a DDR3 PHY.
// Runs RESET#/CKE power-up, MR2/MR3/MR1/MR0 loads and ZQCL, then arbitrates
// the bus between periodic PREA+REF and one upstream valid/ready requester
// (registered, 1-cycle pass-through).
// Ports:
//   clock, reset_n          : clock / async active-low reset
//   cmd_valid_i/cmd_ready_o : upstream handshake
//   cmd_*_ni/_i             : upstream ras/cas/we/odt/bank/addr
//   ready_o                 : initialisation complete
//   refresh_o               : refresh sequence in progress
//   dfi_*                   : registered DFI command bus to the PHY
// Optional feature macro: DDR3_REFRESH_POSTPONE_EN (defer up to 8 refreshes
// while upstream traffic is present).
module ddr3_dfi_sequencer
  import ddr3_seq_pkg::*;
#(
  parameter int                  ADDR_BITS = 14,
  parameter logic [ADDR_BITS-1:0] MR0_VAL  = 14'h0520,
  parameter logic [ADDR_BITS-1:0] MR1_VAL  = 14'h0044,
  parameter logic [ADDR_BITS-1:0] MR2_VAL  = 14'h0008,
  parameter logic [ADDR_BITS-1:0] MR3_VAL  = 14'h0000,
  parameter int T_RESET = 20000,
  parameter int T_CKE   = 50000,
  parameter int T_XPR   = 17,
  parameter int T_MRD   = 4,
  parameter int T_MOD   = 12,
  parameter int T_ZQI   = 512,
  parameter int T_QUIET = 8,
  parameter int T_RP    = 6,
  parameter int T_RFC   = 16,
  parameter int T_REFI  = 780
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic                 cmd_ras_ni,
  input  logic                 cmd_cas_ni,
  input  logic                 cmd_we_ni,
  input  logic                 cmd_odt_i,
  input  logic [2:0]           cmd_bank_i,
  input  logic [ADDR_BITS-1:0] cmd_addr_i,
  output logic                 ready_o,
  output logic                 refresh_o,
  output logic                 dfi_cke_o,
  output logic                 dfi_rst_no,
  output logic                 dfi_cs_no,
  output logic                 dfi_ras_no,
  output logic                 dfi_cas_no,
  output logic                 dfi_we_no,
  output logic                 dfi_odt_o,
  output logic [2:0]           dfi_bank_o,
  output logic [ADDR_BITS-1:0] dfi_addr_o
);

  // One counter width covers every wait; the longest are the power-up waits
  // and tREFI / tZQinit.
  localparam int TW = $clog2(max4(T_RESET, T_CKE, T_REFI, T_ZQI) + 1);
  localparam logic [ADDR_BITS-1:0] ADDR_A10 = {{(ADDR_BITS-11){1'b0}}, 1'b1, 10'b0};

  state_t               state, nxt_state;
  logic                 tmr_load, tmr_exp;
  logic [TW-1:0]        tmr_val;
  logic                 refi_load, refi_exp;
  logic [PEND_W-1:0]    pending, pend_nxt;
  logic                 pend_dec, ref_start, accept;
  logic                 nxt_rst_n, nxt_cke, nxt_odt, nxt_ready, nxt_refresh;
  logic [2:0]           nxt_cmd, nxt_bank;
  logic [ADDR_BITS-1:0] nxt_addr;

  ddr3_wait_timer #(.W(TW), .RST_VAL(T_RESET)) u_seq_tmr (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expire   (tmr_exp)
  );

  // Idle until the first load at end of init, then reloads itself on expiry.
  ddr3_wait_timer #(.W(TW), .RST_VAL(0)) u_refi_tmr (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (refi_load),
    .load_val (TW'(T_REFI)),
    .expire   (refi_exp)
  );

  assign refi_load   = ((state == ST_ZQCL) && tmr_exp) || refi_exp;
  assign cmd_ready_o = (state == ST_IDLE) && (pending < PEND_W'(PEND_MAX));
  assign accept      = cmd_valid_i && cmd_ready_o;
  assign pend_dec    = (state == ST_REF) && tmr_exp;

  // Decrement first so an expiry landing on the same cycle as a completed
  // REF is not lost to saturation.
  always_comb begin
    pend_nxt = pending - PEND_W'(pend_dec);
    if (refi_exp && (pend_nxt < PEND_W'(PEND_MAX))) pend_nxt = pend_nxt + PEND_W'(1);
  end

`ifdef DDR3_REFRESH_POSTPONE_EN
  assign ref_start = (pend_nxt == PEND_W'(PEND_MAX)) || ((pend_nxt != '0) && !cmd_valid_i);
`else
  assign ref_start = (pend_nxt != '0);
`endif

  // Each state is named after the command driven on the bus in its first
  // cycle; the transition edge is the edge that registers that command.
  always_comb begin
    nxt_state = state;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    nxt_rst_n = dfi_rst_no;
    nxt_cke   = dfi_cke_o;
    nxt_ready = ready_o;
    nxt_cmd   = CMD_NOP;
    nxt_odt   = 1'b0;
    nxt_bank  = '0;
    nxt_addr  = '0;
    case (state)
      ST_RESET: if (tmr_exp) begin
        nxt_rst_n = 1'b1;
        tmr_load  = 1'b1;
        tmr_val   = TW'(T_CKE);
        nxt_state = ST_CKEWAIT;
      end
      ST_CKEWAIT: if (tmr_exp) begin
        nxt_cke   = 1'b1;
        tmr_load  = 1'b1;
        tmr_val   = TW'(T_XPR);
        nxt_state = ST_XPR;
      end
      ST_XPR: if (tmr_exp) begin
        nxt_cmd   = CMD_MRS;
        nxt_bank  = 3'd2;
        nxt_addr  = MR2_VAL;
        tmr_load  = 1'b1;
        tmr_val   = TW'(T_MRD);
        nxt_state = ST_MR2;
      end
      ST_MR2: if (tmr_exp) begin
        nxt_cmd   = CMD_MRS;
        nxt_bank  = 3'd3;
        nxt_addr  = MR3_VAL;
        tmr_load  = 1'b1;
        tmr_val   = TW'(T_MRD);
        nxt_state = ST_MR3;
      end
      ST_MR3: if (tmr_exp) begin
        nxt_cmd   = CMD_MRS;
        nxt_bank  = 3'd1;
        nxt_addr  = MR1_VAL;
        tmr_load  = 1'b1;
        tmr_val   = TW'(T_MRD);
        nxt_state = ST_MR1;
      end
      ST_MR1: if (tmr_exp) begin
        nxt_cmd   = CMD_MRS;
        nxt_bank  = 3'd0;
        nxt_addr  = MR0_VAL;
        tmr_load  = 1'b1;
        tmr_val   = TW'(T_MOD);
        nxt_state = ST_MR0;
      end
      ST_MR0: if (tmr_exp) begin
        nxt_cmd   = CMD_ZQC;
        nxt_addr  = ADDR_A10;
        tmr_load  = 1'b1;
        tmr_val   = TW'(T_ZQI);
        nxt_state = ST_ZQCL;
      end
      ST_ZQCL: if (tmr_exp) begin
        nxt_ready = 1'b1;
        nxt_state = ST_IDLE;
      end
      ST_IDLE: begin
        if (accept) begin
          nxt_cmd  = {cmd_ras_ni, cmd_cas_ni, cmd_we_ni};
          nxt_odt  = cmd_odt_i;
          nxt_bank = cmd_bank_i;
          nxt_addr = cmd_addr_i;
        end
        // Quiet window starts on the edge of any coincident accept, so it is
        // never shorter than T_QUIET after the last command.
        if (ref_start) begin
          tmr_load  = 1'b1;
          tmr_val   = TW'(T_QUIET);
          nxt_state = ST_QUIET;
        end
      end
      ST_QUIET: if (tmr_exp) begin
        nxt_cmd   = CMD_PRE;
        nxt_addr  = ADDR_A10;
        tmr_load  = 1'b1;
        tmr_val   = TW'(T_RP);
        nxt_state = ST_PREA;
      end
      ST_PREA: if (tmr_exp) begin
        nxt_cmd   = CMD_REF;
        tmr_load  = 1'b1;
        tmr_val   = TW'(T_RFC);
        nxt_state = ST_REF;
      end
      ST_REF: if (tmr_exp) begin
        if (pend_nxt != '0) begin
          nxt_cmd  = CMD_REF;
          tmr_load = 1'b1;
          tmr_val  = TW'(T_RFC);
        end else begin
          nxt_state = ST_IDLE;
        end
      end
      default: nxt_state = ST_RESET;
    endcase
  end

  assign nxt_refresh = (nxt_state == ST_QUIET) || (nxt_state == ST_PREA) ||
                       (nxt_state == ST_REF);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_RESET;
      pending    <= '0;
      dfi_rst_no <= 1'b0;
      dfi_cke_o  <= 1'b0;
      dfi_cs_no  <= CS_DESELECT;
      {dfi_ras_no, dfi_cas_no, dfi_we_no} <= CMD_NOP;
      dfi_odt_o  <= 1'b0;
      dfi_bank_o <= '0;
      dfi_addr_o <= '0;
      ready_o    <= 1'b0;
      refresh_o  <= 1'b0;
    end else begin
      state      <= nxt_state;
      pending    <= pend_nxt;
      dfi_rst_no <= nxt_rst_n;
      dfi_cke_o  <= nxt_cke;
      // DESELECT only while CKE is low; every command follows CKE high.
      dfi_cs_no  <= nxt_cke ? CS_SELECT : CS_DESELECT;
      {dfi_ras_no, dfi_cas_no, dfi_we_no} <= nxt_cmd;
      dfi_odt_o  <= nxt_odt;
      dfi_bank_o <= nxt_bank;
      dfi_addr_o <= nxt_addr;
      ready_o    <= nxt_ready;
      refresh_o  <= nxt_refresh;
    end
  end

endmodule

// File: tb/tb_ddr3_dfi_sequencer.sv
// tb_ddr3_dfi_sequencer: directed table-driven bench for ddr3_dfi_sequencer
// with shortened timing parameters. Cycle numbers count rising edges after
// reset_n is released (first edge = 1); outputs are sampled 1 ns after edges.
module tb_ddr3_dfi_sequencer;

`ifdef DDR3_REFRESH_POSTPONE_EN
  localparam bit PP = 1'b1;
`else
  localparam bit PP = 1'b0;
`endif
  localparam int D = PP ? 1 : 0;

  localparam logic [13:0] MR0 = 14'h0520;
  localparam logic [13:0] MR1 = 14'h0044;
  localparam logic [13:0] MR2 = 14'h0008;
  localparam logic [13:0] MR3 = 14'h0003;
  localparam logic [13:0] A10 = 14'h0400;

  localparam logic [2:0] NOP = 3'b111, MRS = 3'b000, PRE = 3'b010, REF = 3'b001;
  localparam logic [2:0] ZQC = 3'b110, ACT = 3'b011, WRT = 3'b100, RD  = 3'b101;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        cmd_valid_i, cmd_ready_o, cmd_ras_ni, cmd_cas_ni, cmd_we_ni, cmd_odt_i;
  logic [2:0]  cmd_bank_i;
  logic [13:0] cmd_addr_i;
  logic        ready_o, refresh_o, dfi_cke_o, dfi_rst_no, dfi_cs_no;
  logic        dfi_ras_no, dfi_cas_no, dfi_we_no, dfi_odt_o;
  logic [2:0]  dfi_bank_o;
  logic [13:0] dfi_addr_o;

  ddr3_dfi_sequencer #(
    .ADDR_BITS(14), .MR0_VAL(MR0), .MR1_VAL(MR1), .MR2_VAL(MR2), .MR3_VAL(MR3),
    .T_RESET(10), .T_CKE(20), .T_XPR(3), .T_MRD(4), .T_MOD(6), .T_ZQI(8),
    .T_QUIET(2), .T_RP(3), .T_RFC(5), .T_REFI(100)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_ras_ni(cmd_ras_ni), .cmd_cas_ni(cmd_cas_ni), .cmd_we_ni(cmd_we_ni),
    .cmd_odt_i(cmd_odt_i), .cmd_bank_i(cmd_bank_i), .cmd_addr_i(cmd_addr_i),
    .ready_o(ready_o), .refresh_o(refresh_o),
    .dfi_cke_o(dfi_cke_o), .dfi_rst_no(dfi_rst_no), .dfi_cs_no(dfi_cs_no),
    .dfi_ras_no(dfi_ras_no), .dfi_cas_no(dfi_cas_no), .dfi_we_no(dfi_we_no),
    .dfi_odt_o(dfi_odt_o), .dfi_bank_o(dfi_bank_o), .dfi_addr_o(dfi_addr_o)
  );

  always #5 clock = ~clock;

  int cyc;
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  // {rst_n, cke, cs_n, ras/cas/we, odt, bank, addr, ready, refresh, cmd_ready}
  typedef logic [26:0] snap_t;

  typedef struct {
    int          cyc;
    logic        v;
    logic [2:0]  cmd;
    logic        odt;
    logic [2:0]  bank;
    logic [13:0] addr;
    snap_t       exp;
  } row_t;

  row_t tbl[64];
  int   n_rows = 0;
  int   n_init = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  function automatic snap_t mk(input logic rst, input logic cke, input logic cs,
                               input logic [2:0] cmd, input logic odt,
                               input logic [2:0] bank, input logic [13:0] addr,
                               input logic rdy, input logic rf, input logic crdy);
    return {rst, cke, cs, cmd, odt, bank, addr, rdy, rf, crdy};
  endfunction

  function automatic snap_t act();
    return {dfi_rst_no, dfi_cke_o, dfi_cs_no, dfi_ras_no, dfi_cas_no, dfi_we_no,
            dfi_odt_o, dfi_bank_o, dfi_addr_o, ready_o, refresh_o, cmd_ready_o};
  endfunction

  task automatic add(input int c, input logic v, input logic [2:0] cmd, input logic odt,
                     input logic [2:0] bank, input logic [13:0] addr, input snap_t exp);
    tbl[n_rows] = '{cyc: c, v: v, cmd: cmd, odt: odt, bank: bank, addr: addr, exp: exp};
    n_rows++;
  endtask

  task automatic check(input string nm, input snap_t exp);
    snap_t a;
    a = act();
    n_tests++;
    if (a !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", nm, a, exp);
    end
  endtask

  task automatic check_int(input string nm, input int got, input int req);
    n_tests++;
    if (got != req) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", nm, got, req);
    end
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      while (cyc < tbl[i].cyc - 1) begin
        @(posedge clock);
        #1;
      end
      cmd_valid_i = tbl[i].v;
      {cmd_ras_ni, cmd_cas_ni, cmd_we_ni} = tbl[i].cmd;
      cmd_odt_i  = tbl[i].odt;
      cmd_bank_i = tbl[i].bank;
      cmd_addr_i = tbl[i].addr;
      @(posedge clock);
      #1;
      check($sformatf("bus@cyc%0d", tbl[i].cyc), tbl[i].exp);
      cmd_valid_i = 1'b0;
    end
  endtask

  task automatic release_reset();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  localparam snap_t RST_SNAP = {1'b0, 1'b0, 1'b1, 3'b111, 1'b0, 3'b0, 14'h0, 1'b0, 1'b0, 1'b0};

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_pre, first_ref, last_ref, nref;

    // init sequence
    add(9,  0, NOP, 0, 0, 0, mk(0,0,1,NOP,0,0,0,   0,0,0));
    add(10, 0, NOP, 0, 0, 0, mk(1,0,1,NOP,0,0,0,   0,0,0));
    add(29, 0, NOP, 0, 0, 0, mk(1,0,1,NOP,0,0,0,   0,0,0));
    add(30, 0, NOP, 0, 0, 0, mk(1,1,0,NOP,0,0,0,   0,0,0));
    add(32, 0, NOP, 0, 0, 0, mk(1,1,0,NOP,0,0,0,   0,0,0));
    add(33, 0, NOP, 0, 0, 0, mk(1,1,0,MRS,0,2,MR2, 0,0,0));
    add(34, 0, NOP, 0, 0, 0, mk(1,1,0,NOP,0,0,0,   0,0,0));
    add(37, 0, NOP, 0, 0, 0, mk(1,1,0,MRS,0,3,MR3, 0,0,0));
    add(41, 0, NOP, 0, 0, 0, mk(1,1,0,MRS,0,1,MR1, 0,0,0));
    add(45, 0, NOP, 0, 0, 0, mk(1,1,0,MRS,0,0,MR0, 0,0,0));
    add(50, 0, NOP, 0, 0, 0, mk(1,1,0,NOP,0,0,0,   0,0,0));
    add(51, 0, NOP, 0, 0, 0, mk(1,1,0,ZQC,0,0,A10, 0,0,0));
    add(58, 0, NOP, 0, 0, 0, mk(1,1,0,NOP,0,0,0,   0,0,0));
    add(59, 0, NOP, 0, 0, 0, mk(1,1,0,NOP,0,0,0,   1,0,1));
    n_init = n_rows;
    // first refresh, no traffic
    add(158, 0, NOP, 0, 0, 0, mk(1,1,0,NOP,0,0,0,  1,0,1));
    add(159, 0, NOP, 0, 0, 0, mk(1,1,0,NOP,0,0,0,  1,1,0));
    add(161, 0, NOP, 0, 0, 0, mk(1,1,0,PRE,0,0,A10,1,1,0));
    add(163, 0, NOP, 0, 0, 0, mk(1,1,0,NOP,0,0,0,  1,1,0));
    add(164, 0, NOP, 0, 0, 0, mk(1,1,0,REF,0,0,0,  1,1,0));
    add(168, 0, NOP, 0, 0, 0, mk(1,1,0,NOP,0,0,0,  1,1,0));
    add(169, 0, NOP, 0, 0, 0, mk(1,1,0,NOP,0,0,0,  1,0,1));
    // pass-through traffic
    add(180, 1, ACT, 1, 5, 14'h0123, mk(1,1,0,ACT,1,5,14'h0123, 1,0,1));
    add(181, 0, NOP, 0, 0, 0,        mk(1,1,0,NOP,0,0,0,        1,0,1));
    add(200, 1, WRT, 1, 2, 14'h00ab, mk(1,1,0,WRT,1,2,14'h00ab, 1,0,1));
    add(201, 0, NOP, 0, 0, 0,        mk(1,1,0,NOP,0,0,0,        1,0,1));
    // command coincident with the second tREFI expiry
    add(259, 1, RD, 0, 3, 14'h0055,  mk(1,1,0,RD,0,3,14'h0055, 1, PP ? 1'b0 : 1'b1, PP));
    add(260, 0, NOP, 0, 0, 0,        mk(1,1,0,NOP,0,0,0,   1,1,0));
    add(261+D, 0, NOP, 0, 0, 0,      mk(1,1,0,PRE,0,0,A10, 1,1,0));
    add(264+D, 0, NOP, 0, 0, 0,      mk(1,1,0,REF,0,0,0,   1,1,0));
    add(269+D, 0, NOP, 0, 0, 0,      mk(1,1,0,NOP,0,0,0,   1,0,1));

    reset_n = 1'b0;
    cmd_valid_i = 1'b0;
    {cmd_ras_ni, cmd_cas_ni, cmd_we_ni} = NOP;
    cmd_odt_i = 1'b0;
    cmd_bank_i = '0;
    cmd_addr_i = '0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_values", RST_SNAP);
    @(negedge clock);
    reset_n = 1'b1;
    run_rows(0, n_rows);

    // async reset from idle
    reset_n = 1'b0;
    #1;
    check("reset_from_idle", RST_SNAP);
    release_reset();

    // reset while waiting in ST_MR1, then full replay
    while (cyc < 43) begin
      @(posedge clock);
      #1;
    end
    check("mr1_wait_nop", mk(1,1,0,NOP,0,0,0,0,0,0));
    #2;
    reset_n = 1'b0;
    #1;
    check("reset_in_mr1", RST_SNAP);
    release_reset();
    run_rows(0, n_init);

    // upstream valid held high for 1000 cycles
    cmd_valid_i = 1'b1;
    {cmd_ras_ni, cmd_cas_ni, cmd_we_ni} = RD;
    cmd_bank_i = 3'd1;
    cmd_addr_i = 14'h0010;
    first_pre = -1;
    first_ref = -1;
    last_ref = -1;
    nref = 0;
    for (int k = 0; k < 1000; k++) begin
      @(posedge clock);
      #1;
      if (!dfi_cs_no && {dfi_ras_no, dfi_cas_no, dfi_we_no} == PRE && first_pre < 0)
        first_pre = cyc;
      if (!dfi_cs_no && {dfi_ras_no, dfi_cas_no, dfi_we_no} == REF && first_pre >= 0 &&
          cyc < first_pre + 45) begin
        if (first_ref < 0) first_ref = cyc;
        last_ref = cyc;
        nref++;
      end
    end
    cmd_valid_i = 1'b0;
    check_int("first_prea_cycle", first_pre, PP ? 861 : 161);
    check_int("prea_to_ref", first_ref - first_pre, 3);
    check_int("ref_count", nref, PP ? 8 : 1);
    check_int("ref_spacing", last_ref - first_ref, PP ? 35 : 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
